// File: rtl/video_rx_fifo_writer_if.sv
// Parallel video input plus frame FIFO write port of the video receive path.
// The source side (stream generator + FIFO) uses master; the writer uses slave.
interface video_rx_fifo_writer_if;
    logic        hsync;
    logic        vsync;
    logic        dataEnable;
    logic [23:0] RGBchannel;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_data_out;

    modport master (
        output hsync,
        output vsync,
        output dataEnable,
        output RGBchannel,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_data_out
    );

    modport slave (
        input  hsync,
        input  vsync,
        input  dataEnable,
        input  RGBchannel,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_data_out
    );
endinterface

// File: rtl/video_rx_fifo_writer.sv
// Captures a parallel RGB888 video stream, packs it to RGB565 into a frame FIFO and
// checks frame geometry, reporting overflow/geometry errors and frame lock.
module video_rx_fifo_writer #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2
) (
    input  logic                   clock25,
    input  logic                   resetn,
    video_rx_fifo_writer_if.slave  bus,
    input  logic                   err_clr_i,
    output logic [9:0]             pixel_x_o,
    output logic [8:0]             pixel_y_o,
    output logic                   frame_done_o,
    output logic                   overflow_err_o,
    output logic                   geom_err_o,
    output logic                   frame_locked_o
);

    localparam int unsigned LineW = $clog2(V_ACTIVE + 1);
    localparam int unsigned GoodW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrop} state_e;

    state_e             state_q, state_d;
    logic               hs1_q, vs1_q, de1_q, full1_q, vs2_q, de2_q;
    logic [23:0]        rgb1_q;
    logic [9:0]         pixel_x_q, pixel_x_d;
    logic [8:0]         pixel_y_q, pixel_y_d;
    logic [LineW-1:0]   lines_q, lines_d;
    logic [GoodW-1:0]   good_q, good_d;
    logic               bad_q, bad_d;
    logic               locked_q, locked_d;
    logic               wr_en_q, wr_en_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               geom_q, geom_d;

    logic vs_edge, de_rise, de_fall;
    logic take_pixel, line_end, frame_end, geom_ev, ovf_ev;
    logic frame_good;

    assign vs_edge = vs1_q & ~vs2_q;
    assign de_rise = de1_q & ~de2_q;
    assign de_fall = ~de1_q & de2_q;

    always_comb begin
        state_d    = state_q;
        pixel_x_d  = pixel_x_q;
        pixel_y_d  = pixel_y_q;
        lines_d    = lines_q;
        good_d     = good_q;
        locked_d   = locked_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        take_pixel = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        geom_ev    = 1'b0;
        ovf_ev     = 1'b0;
        frame_good = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (vs_edge) state_d = StArmed;
            end
            StArmed: begin
                if (!vs_edge && de_rise) begin
                    take_pixel = 1'b1;
                    state_d    = StCapture;
                end
            end
            StCapture: begin
                line_end = de_fall;
                if (vs_edge) begin
                    // Boundary wins over a coincident pixel, which marks the stream malformed.
                    frame_end = 1'b1;
                    geom_ev   = de1_q;
                    state_d   = StArmed;
                end else begin
                    take_pixel = de1_q;
                end
            end
            StDrop: begin
                if (vs_edge) state_d = StArmed;
            end
            default: state_d = StIdle;
        endcase

        if (take_pixel) begin
            if (de_rise) pixel_x_d = '0;
            else if (pixel_x_q != '1) pixel_x_d = pixel_x_q + 10'd1;
            if (hs1_q) geom_ev = 1'b1;
            if (full1_q) begin
                ovf_ev   = 1'b1;
                good_d   = '0;
                locked_d = 1'b0;
                state_d  = StDrop;
            end else begin
                wr_en_d = 1'b1;
                data_d  = {rgb1_q[23:19], rgb1_q[15:10], rgb1_q[7:3]};
            end
        end

        if (line_end) begin
            if (({1'b0, pixel_x_q} + 11'd1) != 11'(H_ACTIVE)) geom_ev = 1'b1;
            pixel_x_d = '0;
            if (lines_q >= LineW'(V_ACTIVE)) geom_ev = 1'b1;
            else lines_d = lines_q + 1'b1;
            if (pixel_y_q != 9'(V_ACTIVE - 1)) pixel_y_d = pixel_y_q + 9'd1;
        end

        // lines_d already includes a line that ends in the boundary cycle.
        if (frame_end) begin
            if (lines_d != LineW'(V_ACTIVE)) geom_ev = 1'b1;
            frame_good = !geom_ev && !bad_q;
            if (frame_good) begin
                done_d = 1'b1;
                if (good_q != GoodW'(LOCK_FRAMES)) good_d = good_q + 1'b1;
                if (good_d == GoodW'(LOCK_FRAMES)) locked_d = 1'b1;
            end else begin
                good_d   = '0;
                locked_d = 1'b0;
            end
        end

        if (vs_edge) begin
            pixel_x_d = '0;
            pixel_y_d = '0;
            lines_d   = '0;
        end

        bad_d  = vs_edge ? 1'b0 : (bad_q | geom_ev | ovf_ev);
        geom_d = geom_ev | (geom_q & ~err_clr_i);
        ovf_d  = ovf_ev | (ovf_q & ~err_clr_i);
    end

    always_ff @(posedge clock25) begin
        if (!resetn) begin
            state_q   <= StIdle;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            full1_q   <= 1'b0;
            rgb1_q    <= '0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
            pixel_x_q <= '0;
            pixel_y_q <= '0;
            lines_q   <= '0;
            good_q    <= '0;
            bad_q     <= 1'b0;
            locked_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            geom_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs1_q     <= bus.hsync ^ SYNC_ACTIVE_LOW;
            vs1_q     <= bus.vsync ^ SYNC_ACTIVE_LOW;
            de1_q     <= bus.dataEnable;
            full1_q   <= bus.fifo_full;
            rgb1_q    <= bus.RGBchannel;
            vs2_q     <= vs1_q;
            de2_q     <= de1_q;
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
            lines_q   <= lines_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked_q  <= locked_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            geom_q    <= geom_d;
        end
    end

    assign bus.fifo_wr_en    = wr_en_q;
    assign bus.fifo_data_out = data_q;
    assign pixel_x_o         = pixel_x_q;
    assign pixel_y_o         = pixel_y_q;
    assign frame_done_o      = done_q;
    assign overflow_err_o    = ovf_q;
    assign geom_err_o        = geom_q;
    assign frame_locked_o    = locked_q;

endmodule

// File: tb/tb_video_rx_fifo_writer.sv
// Bench for video_rx_fifo_writer: two instances (low- and high-active syncs) fed the same
// small-geometry stream, compared against a frame-level model of expected writes and flags.
module tb_video_rx_fifo_writer;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned LOCK = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic err_clr = 1'b0;

    video_rx_fifo_writer_if bus_l ();
    video_rx_fifo_writer_if bus_h ();

    logic [9:0] px_l, px_h;
    logic [8:0] py_l, py_h;
    logic       done_l, done_h, ovf_l, ovf_h, geom_l, geom_h, lock_l, lock_h;

    video_rx_fifo_writer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LOCK)
    ) dut_l (
        .clock25(clk), .resetn(resetn), .bus(bus_l), .err_clr_i(err_clr),
        .pixel_x_o(px_l), .pixel_y_o(py_l), .frame_done_o(done_l),
        .overflow_err_o(ovf_l), .geom_err_o(geom_l), .frame_locked_o(lock_l)
    );

    video_rx_fifo_writer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(LOCK)
    ) dut_h (
        .clock25(clk), .resetn(resetn), .bus(bus_h), .err_clr_i(err_clr),
        .pixel_x_o(px_h), .pixel_y_o(py_h), .frame_done_o(done_h),
        .overflow_err_o(ovf_h), .geom_err_o(geom_h), .frame_locked_o(lock_h)
    );

    always #20 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame-level reference model state
    bit m_cap = 0, m_drop = 0, m_bad = 0, m_locked = 0, m_ovf = 0, m_geom = 0;
    int m_good = 0;
    int exp_done = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_l[$];
    logic [15:0] got_h[$];
    int done_cnt_l = 0, done_cnt_h = 0;

    always @(negedge clk) begin
        if (bus_l.fifo_wr_en) got_l.push_back(bus_l.fifo_data_out);
        if (bus_h.fifo_wr_en) got_h.push_back(bus_h.fifo_data_out);
        if (done_l) done_cnt_l++;
        if (done_h) done_cnt_h++;
    end

    function automatic logic [15:0] pack(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit hs, input bit vs, input bit de, input logic [23:0] rgb,
                         input bit full, input bit clr);
        bus_l.hsync = ~hs;  bus_l.vsync = ~vs;
        bus_h.hsync = hs;   bus_h.vsync = vs;
        bus_l.dataEnable = de;  bus_h.dataEnable = de;
        bus_l.RGBchannel = rgb; bus_h.RGBchannel = rgb;
        bus_l.fifo_full  = full; bus_h.fifo_full = full;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_l_a"}, {6'd0, bus_l.fifo_wr_en, bus_l.fifo_data_out, px_l}, 32'd0);
        check({tag, "_l_b"}, {py_l, done_l, ovf_l, geom_l, lock_l}, 32'd0);
        check({tag, "_h_a"}, {6'd0, bus_h.fifo_wr_en, bus_h.fifo_data_out, px_h}, 32'd0);
        check({tag, "_h_b"}, {py_h, done_h, ovf_h, geom_h, lock_h}, 32'd0);
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        drive(0, 0, 0, 24'h0, 0, 0);
        check_reset_outputs("mid_reset");
        resetn = 1'b1;
        m_cap = 0; m_drop = 0; m_bad = 0; m_good = 0; m_locked = 0; m_ovf = 0; m_geom = 0;
    endtask

    // Vsync pulse; evaluates the previous frame and compares everything seen since.
    task automatic boundary(input bit clr);
        int mis_l, mis_h;
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 24'h0, 0, 0);
        for (int k = 0; k < 2; k++) drive(0, 0, 0, 24'h0, 0, 0);
        if (m_cap && !m_drop) begin
            if (!m_bad) begin
                exp_done++;
                if (m_good < LOCK) m_good++;
                if (m_good == LOCK) m_locked = 1;
            end else begin
                m_good = 0;
                m_locked = 0;
            end
        end
        mis_l = 0; mis_h = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= got_l.size() || got_l[k] !== exp_q[k]) mis_l++;
            if (k >= got_h.size() || got_h[k] !== exp_q[k]) mis_h++;
        end
        check("wr_count_l", got_l.size(), exp_q.size());
        check("wr_data_l", mis_l, 0);
        check("wr_count_h", got_h.size(), exp_q.size());
        check("wr_data_h", mis_h, 0);
        check("frame_done_l", done_cnt_l, exp_done);
        check("frame_done_h", done_cnt_h, exp_done);
        check("locked", {lock_l, lock_h}, {m_locked, m_locked});
        check("overflow_err", {ovf_l, ovf_h}, {m_ovf, m_ovf});
        check("geom_err", {geom_l, geom_h}, {m_geom, m_geom});
        exp_q.delete(); got_l.delete(); got_h.delete();
        if (clr) begin
            drive(0, 0, 0, 24'h0, 0, 1);
            m_ovf = 0; m_geom = 0;
            check("err_clr", {ovf_l, ovf_h, geom_l, geom_h}, 4'b0);
            check("err_clr_lock", {lock_l, lock_h}, {m_locked, m_locked});
        end
        m_cap = 1; m_drop = 0; m_bad = 0;
    endtask

    task automatic frame(input bit with_vs, input int short_line, input int full_line,
                         input int full_pix, input int rst_line, input bit rgb_test,
                         input bit clr);
        logic [23:0] rgb;
        int len;
        bit full;
        if (with_vs) boundary(clr);
        for (int j = 0; j < V; j++) begin
            len = (j == short_line) ? H - 1 : H;
            for (int i = 0; i < len; i++) begin
                rgb = 24'($urandom);
                if (rgb_test && j == 0 && i == 0) rgb = 24'hFF0000;
                if (rgb_test && j == 0 && i == 1) rgb = 24'h00FF00;
                if (rgb_test && j == 0 && i == 2) rgb = 24'h0000FF;
                full = (j == full_line) && (i == full_pix);
                drive(0, 0, 1, rgb, full, 0);
                if (m_cap && !m_drop) begin
                    if (full) begin
                        m_drop = 1; m_ovf = 1; m_good = 0; m_locked = 0;
                    end else begin
                        exp_q.push_back(pack(rgb));
                    end
                end
                if (rgb_test && j == 0) begin
                    if (i == 0) check("lat_no_early_wr", bus_l.fifo_wr_en, 1'b0);
                    if (i == 1) check("rgb_red", {bus_l.fifo_wr_en, bus_l.fifo_data_out},
                                      {1'b1, 16'hF800});
                    if (i == 2) check("rgb_green", {bus_l.fifo_wr_en, bus_l.fifo_data_out},
                                      {1'b1, 16'h07E0});
                    if (i == 2) check("pixel_x_mid", px_l, 10'd1);
                    if (i == 3) check("rgb_blue", {bus_h.fifo_wr_en, bus_h.fifo_data_out},
                                      {1'b1, 16'h001F});
                end
            end
            if (j == short_line && m_cap && !m_drop) begin
                m_bad = 1; m_geom = 1;
            end
            drive(1, 0, 0, 24'h0, 0, 0);
            drive(1, 0, 0, 24'h0, 0, 0);
            drive(0, 0, 0, 24'h0, 0, 0);
            drive(0, 0, 0, 24'h0, 0, 0);
            if (m_cap && !m_drop) begin
                check("pixel_x_eol", {px_l, px_h}, 20'd0);
                check("pixel_y_eol", {py_l, py_h},
                      {9'((j + 1 < V) ? j + 1 : V - 1), 9'((j + 1 < V) ? j + 1 : V - 1)});
            end
            if (j == rst_line) reset_pulse();
        end
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 24'h0, 0, 0);
    endtask

    initial begin
        bus_l.hsync = 1'b1; bus_l.vsync = 1'b1; bus_h.hsync = 1'b0; bus_h.vsync = 1'b0;
        bus_l.dataEnable = 1'b0; bus_h.dataEnable = 1'b0;
        bus_l.RGBchannel = '0; bus_h.RGBchannel = '0;
        bus_l.fifo_full = 1'b0; bus_h.fifo_full = 1'b0;
        resetn = 1'b0;
        drive(0, 0, 0, 24'h0, 0, 0);
        drive(0, 0, 0, 24'h0, 0, 0);
        check_reset_outputs("reset");
        resetn = 1'b1;

        frame(0, -1, -1, 0, -1, 0, 0);   // mid-frame start: ignored until first vsync
        frame(1, -1, -1, 0, -1, 1, 0);   // first captured frame, RGB565 packing
        frame(1, -1, -1, 0, -1, 0, 0);
        frame(1, -1, -1, 0, -1, 0, 0);   // lock reached here
        frame(1, -1,  1, 3, -1, 0, 0);   // overflow at line 1 pixel 3
        frame(1, -1, -1, 0, -1, 0, 1);
        frame(1,  2, -1, 0, -1, 0, 0);   // one short line
        frame(1, -1, -1, 0, -1, 0, 1);
        frame(1, -1, -1, 0, -1, 0, 0);
        frame(1, -1, -1, 0,  2, 0, 0);   // reset pulse after line 2
        frame(1, -1, -1, 0, -1, 0, 0);
        frame(1, -1, -1, 0, -1, 0, 0);
        frame(1, -1, -1, 0, -1, 0, 0);
        for (int r = 0; r < 5; r++) begin
            frame(1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : -1,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, V - 1)) : -1,
                  int'($urandom_range(0, H - 1)), -1, 0, 1);
        end
        boundary(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
